// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an external servo PWM line
// in clk counts, strobes each accepted period, flags out-of-range pulses and
// loss of signal.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no period in progress; waiting for a rising edge to start one
// HIGH  | line is high; counting both high time and period
// LOW   | line is low; counting period, next rising edge closes the period
module pwm_capture #(
    parameter int unsigned MIN_HIGH = 25_000,
    parameter int unsigned MAX_HIGH = 125_000,
    parameter int unsigned TIMEOUT  = 1_048_575
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [19:0] duty_out,
    output logic [19:0] period_out,
    output logic        duty_valid,
    output logic        duty_err,
    output logic        signal_lost
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [19:0] CNT_MAX = 20'hF_FFFF;
    localparam logic [19:0] MIN_C   = 20'(MIN_HIGH);
    localparam logic [19:0] MAX_C   = 20'(MAX_HIGH);
    localparam logic [19:0] TO_C    = 20'(TIMEOUT);

    logic        s1, s2, s3;
    logic        rise, fall;
    logic [1:0]  state;
    logic [19:0] hi_cnt, per_cnt;
    logic [19:0] hi_inc, per_inc;
    logic        timed_out;
    logic        in_range;

    // Two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Counters stick at full scale instead of wrapping to a small value
    assign hi_inc  = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + 20'd1;
    assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + 20'd1;

    assign timed_out = (per_cnt == TO_C);
    assign in_range  = (hi_cnt >= MIN_C) && (hi_cnt <= MAX_C);

    // Measurement FSM, counters and registered results/strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            hi_cnt      <= 20'd0;
            per_cnt     <= 20'd0;
            duty_out    <= 20'd0;
            period_out  <= 20'd0;
            duty_valid  <= 1'b0;
            duty_err    <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            duty_valid <= 1'b0;
            duty_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        hi_cnt  <= 20'd1;
                        per_cnt <= 20'd1;
                        state   <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // Timeout wins over any edge seen in the same cycle
                    if (timed_out) begin
                        state       <= ST_IDLE;
                        signal_lost <= 1'b1;
                    end else begin
                        per_cnt <= per_inc;
                        if (s2) begin
                            hi_cnt <= hi_inc;
                        end
                        if (fall) begin
                            state <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    if (timed_out) begin
                        state       <= ST_IDLE;
                        signal_lost <= 1'b1;
                    end else if (rise) begin
                        if (in_range) begin
                            duty_out    <= hi_cnt;
                            period_out  <= per_cnt;
                            duty_valid  <= 1'b1;
                            signal_lost <= 1'b0;
                        end else begin
                            duty_err <= 1'b1;
                        end
                        // This rising edge also opens the next period
                        hi_cnt  <= 20'd1;
                        per_cnt <= 20'd1;
                        state   <= ST_HIGH;
                    end else begin
                        per_cnt <= per_inc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture using scaled timing parameters so that full
// periods, range limits and timeouts fit in a short run.
`timescale 1ns/1ps
module tb_pwm_capture;

    logic        clk;
    logic        rst;
    logic        pwm;
    logic        pwm_min;
    logic [19:0] duty, per;
    logic        dv, de, lost;
    logic [19:0] duty_m, per_m;
    logic        dv_m, de_m, lost_m;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    int nerr   = 0;
    int v0, e0, cnt_m;

    pwm_capture #(.MIN_HIGH(25), .MAX_HIGH(125), .TIMEOUT(600)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm),
        .duty_out(duty), .period_out(per),
        .duty_valid(dv), .duty_err(de), .signal_lost(lost)
    );

    pwm_capture #(.MIN_HIGH(1), .MAX_HIGH(125), .TIMEOUT(600)) dut_min (
        .clk(clk), .rst(rst), .pwm_in(pwm_min),
        .duty_out(duty_m), .period_out(per_m),
        .duty_valid(dv_m), .duty_err(de_m), .signal_lost(lost_m)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Running strobe counts of the main instance
    always @(posedge clk) begin
        if (dv) nvalid <= nvalid + 1;
        if (de) nerr <= nerr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One period: high for h cycles out of p. Its opening rising edge closes
    // the previous period, whose result (kind 0 none, 1 valid, 2 err) must
    // appear exactly on the 3rd edge and last one cycle.
    task automatic drive(input int h, input int p, input int kind, input int ed, input int ep);
        pwm = 1'b1;
        for (int i = 1; i <= p; i++) begin
            @(negedge clk);
            if (i == h) pwm = 1'b0;
            if (i == 2) chk("pre_strobe", {30'd0, dv, de}, 32'd0);
            if (i == 3) begin
                chk("duty_valid", {31'd0, dv}, (kind == 1) ? 32'd1 : 32'd0);
                chk("duty_err", {31'd0, de}, (kind == 2) ? 32'd1 : 32'd0);
                chk("duty_out", {12'd0, duty}, ed);
                chk("period_out", {12'd0, per}, ep);
            end
            if (i == 4) chk("post_strobe", {30'd0, dv, de}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        pwm = 1'b0;
        pwm_min = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_duty", {12'd0, duty}, 32'd0);
        chk("rst_period", {12'd0, per}, 32'd0);
        chk("rst_valid", {31'd0, dv}, 32'd0);
        chk("rst_err", {31'd0, de}, 32'd0);
        chk("rst_lost", {31'd0, lost}, 32'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Nominal: first edge only starts counting
        drive(75, 400, 0, 0, 0);
        chk("lost_before_first", {31'd0, lost}, 32'd1);
        drive(75, 400, 1, 75, 400);
        chk("lost_after_first", {31'd0, lost}, 32'd0);
        drive(75, 400, 1, 75, 400);

        // Range limits
        drive(25, 400, 1, 75, 400);
        drive(125, 400, 1, 25, 400);
        drive(24, 400, 1, 125, 400);
        drive(126, 400, 2, 125, 400);
        drive(75, 400, 2, 125, 400);

        // Timeout with line held low: per_cnt hits 600 after edge 602
        v0 = nvalid; e0 = nerr;
        for (int j = 401; j <= 610; j++) begin
            @(negedge clk);
            if (j == 602) chk("lost_low_before", {31'd0, lost}, 32'd0);
            if (j == 603) chk("lost_low_at", {31'd0, lost}, 32'd1);
        end
        chk("timeout_low_duty", {12'd0, duty}, 32'd125);
        chk("timeout_low_period", {12'd0, per}, 32'd400);
        chk("timeout_low_nostrobe", nvalid + nerr, v0 + e0);
        drive(100, 400, 0, 125, 400);

        // Timeout with line held high
        pwm = 1'b1;
        for (int j = 1; j <= 610; j++) begin
            @(negedge clk);
            if (j == 3) chk("hold_high_close", {31'd0, dv}, 32'd1);
            if (j == 602) chk("lost_high_before", {31'd0, lost}, 32'd0);
            if (j == 603) chk("lost_high_at", {31'd0, lost}, 32'd1);
        end
        chk("timeout_high_duty", {12'd0, duty}, 32'd100);
        chk("timeout_high_period", {12'd0, per}, 32'd400);
        pwm = 1'b0;
        repeat (20) @(negedge clk);
        drive(100, 400, 0, 100, 400);

        // Reset 50 cycles into a high phase. The synchronizers restart and
        // see the still-high line as a fresh rising edge (starts counting
        // only), so the next closing edge reports the remaining 49-cycle
        // high time over a 349-cycle span.
        pwm = 1'b1;
        for (int j = 1; j <= 400; j++) begin
            @(negedge clk);
            if (j == 3) begin
                chk("pre_rst_valid", {31'd0, dv}, 32'd1);
                chk("pre_rst_duty", {12'd0, duty}, 32'd100);
            end
            if (j == 50) rst = 1'b1;
            if (j == 51) begin
                chk("midrst_duty", {12'd0, duty}, 32'd0);
                chk("midrst_period", {12'd0, per}, 32'd0);
                chk("midrst_lost", {31'd0, lost}, 32'd1);
                chk("midrst_strobes", {30'd0, dv, de}, 32'd0);
                rst = 1'b0;
                v0 = nvalid; e0 = nerr;
            end
            if (j == 100) pwm = 1'b0;
        end
        chk("midrst_nostrobe", nvalid + nerr, v0 + e0);
        drive(100, 400, 1, 49, 349);
        drive(100, 400, 1, 100, 400);

        // Step change 50 -> 50 -> 100
        drive(50, 400, 1, 100, 400);
        drive(50, 400, 1, 50, 400);
        drive(100, 400, 1, 50, 400);
        drive(100, 400, 1, 100, 400);

        // Minimum pulses on the MIN_HIGH=1 instance
        cnt_m = 0;
        for (int i = 0; i < 40; i++) begin
            pwm_min = (i % 2 == 0);
            @(negedge clk);
            chk("min_no_err", {31'd0, de_m}, 32'd0);
            if (dv_m) begin
                cnt_m++;
                chk("min_duty", {12'd0, duty_m}, 32'd1);
                chk("min_period", {12'd0, per_m}, 32'd2);
            end
        end
        chk("min_strobe_count", cnt_m, 32'd18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Servo-PWM capture block, the receive-side counterpart of the servo PWM generator. It samples an external PWM line, measures high time and period in 50 MHz `clk` counts (50_000 = 1 ms), and reports each completed period with a one-cycle strobe. Results use the same units as the generator's `duty_need`, so a captured value can be forwarded straight to a servo channel. It also flags out-of-range pulses and loss of signal.

## Interface
- `MIN_HIGH`, default 25_000: minimum accepted high time in clk counts (0.5 ms).
- `MAX_HIGH`, default 125_000: maximum accepted high time in clk counts (2.5 ms).
- `TIMEOUT`, default 1_048_575: count of period cycles without a rising edge that declares signal loss. Range 2..1_048_575.

- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `pwm_in`  in  1  asynchronous external PWM line.
- `duty_out`  out  20  last accepted high time, in clk counts.
- `period_out`  out  20  last accepted rising-to-rising period, in clk counts.
- `duty_valid`  out  1  one-cycle strobe; `duty_out` and `period_out` updated this cycle.
- `duty_err`  out  1  one-cycle strobe; completed period rejected, outputs held.
- `signal_lost`  out  1  level; no valid measurement since reset or since the last timeout.

## Operation
- Input path:
  - `pwm_in` passes through 2 synchronizer flops (`s1`, `s2`), then a history flop `s3`.
  - `rise` = `s2 & ~s3`; `fall` = `~s2 & s3`.
- Counters:
  - `hi_cnt` and `per_cnt` are 20 bits wide and saturate at 1_048_575 (no wrap-around).
- FSM states:
  - **IDLE**: wait for `rise`. On `rise`: `hi_cnt`<=1, `per_cnt`<=1, go to HIGH. `fall` is ignored.
  - **HIGH**: `per_cnt`++ every cycle. `hi_cnt`++ every cycle while `s2`=1. On `fall`: freeze `hi_cnt`, go to LOW.
  - **LOW**: `per_cnt`++ every cycle. On `rise`, the period completes:
    - If MIN_HIGH <= `hi_cnt` <= MAX_HIGH: `duty_out`<=`hi_cnt`, `period_out`<=`per_cnt`, `duty_valid`<=1, `signal_lost`<=0.
    - Otherwise: `duty_err`<=1 and outputs hold.
    - In both cases: `hi_cnt`<=1, `per_cnt`<=1, stay measuring (go to HIGH).
- Timeout:
  - In HIGH or LOW, when `per_cnt` == TIMEOUT: go to IDLE, `signal_lost`<=1, no strobe.
  - `duty_out` and `period_out` hold their last values.
  - Timeout takes priority over a `rise` or `fall` in the same cycle.
- A high time of N cycles on the synchronized input yields `duty_out` = N. A period of P cycles yields `period_out` = P.
- `duty_valid` and `duty_err` are never high in the same cycle.

## Timing
- Reset values: `duty_out`=0, `period_out`=0, `duty_valid`=0, `duty_err`=0, `signal_lost`=1, FSM=IDLE, `s1`/`s2`/`s3`=0, counters=0.
- `rst` mid-measurement aborts it on the next edge; no strobe is issued. The first `rise` after reset only starts counting.
- Latency: a `pwm_in` rising edge that closes a period produces `duty_valid`/`duty_err` high in the cycle after the 3rd rising `clk` edge that samples it. That is 2 synchronizer stages plus 1 output register.
- Strobes last exactly one cycle. There is no back-pressure; a consumer that misses a strobe loses that sample.
- Minimum resolvable pulse: a high or low time of 1 cycle is measured correctly. Sub-cycle glitches may be missed.
- The first complete period after IDLE reports on its closing rising edge, i.e. one full period plus latency after the signal appears.

## Test plan
- **Nominal**: 1.5 ms high / 20 ms period (75_000 / 1_000_000 cycles), repeated 3 times.
  - Required: first edge gives no strobe.
  - Then 2 strobes with `duty_out`=75_000, `period_out`=1_000_000.
  - `signal_lost` falls with the first strobe.
- **Range limits**: high times 25_000, 125_000, 24_999, 125_001.
  - Required: first two produce `duty_valid`.
  - Last two produce `duty_err`, with `duty_out` holding 125_000.
- **Timeout**: nominal signal, then `pwm_in` held low.
  - Required: `signal_lost`=1 exactly when `per_cnt` reaches 1_048_575.
  - FSM returns to IDLE and outputs hold.
  - Repeat with `pwm_in` held high: same result.
- **Reset mid-period**: assert `rst` for 1 cycle 10_000 cycles into a high phase.
  - Required: all outputs return to reset values.
  - No strobe on the next edge; the next complete period reports correctly.
- **Step change**: 1.0 ms high for 2 periods, then 2.0 ms high.
  - Required: `duty_out` goes 50_000, 50_000, 100_000, each with a one-cycle `duty_valid`.
  - Latency equals 3 clk edges from each closing rising edge.
- **Minimum pulses**: high=1, low=1 cycle repeated, with MIN_HIGH overridden to 1.
  - Required: `duty_out`=1, `period_out`=2 on every strobe.
